// File: rtl/ram_prog_sequencer.sv
// ram_prog_sequencer: loads a 16-word program RAM from a host, then hands the
// RAM bus to the run-mode controller. A six-state FSM sequences
// program / write / clear / run / halt. Everything is registered except
// ram_addr and ram_n_ce while running, which follow the controller directly.
module ram_prog_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_clr,
  input  logic              prog_mode,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              hlt,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic              ctrl_n_ce,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_n_ce,
  output logic              cpu_n_clr,
  output logic              run_en,
  output logic              halted,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [2:0] {
    S_STOP,
    S_PROG,
    S_WRITE,
    S_CLEAR,
    S_RUN,
    S_HALTED
  } state_t;

  // Saturation ceiling for wr_count: one count per RAM word.
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic              w_capture;
  logic [ADDR_W:0]   w_count_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_wr_ready;
  logic              r_ram_we;
  logic              r_cpu_n_clr;
  logic              r_run_en;
  logic              r_halted;

  // Next-state decode and host-write capture / counter update.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_count_next = r_wr_count;
    case (r_state)
      S_STOP: begin
        if (prog_mode) begin
          w_state_next = S_PROG;
          w_count_next = '0;
        end else if (start) begin
          w_state_next = S_CLEAR;
        end
      end
      S_PROG: begin
        // A pending write is taken even if the host is leaving program mode.
        if (wr_valid) begin
          w_state_next = S_WRITE;
          w_capture    = 1'b1;
          if (r_wr_count != CNT_MAX) begin
            w_count_next = r_wr_count + 1'b1;
          end
        end else if (!prog_mode) begin
          w_state_next = S_STOP;
        end
      end
      S_WRITE: begin
        w_state_next = prog_mode ? S_PROG : S_STOP;
      end
      S_CLEAR: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (prog_mode) begin
          w_state_next = S_STOP;
        end else if (hlt) begin
          w_state_next = S_HALTED;
        end
      end
      S_HALTED: begin
        if (prog_mode) begin
          w_state_next = S_PROG;
          w_count_next = '0;
        end else if (start) begin
          w_state_next = S_CLEAR;
        end
      end
      default: begin
        w_state_next = S_STOP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_state <= S_STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered outputs, decoded from the state being entered so they line up
  // with the state register cycle for cycle.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_addr      <= '0;
      r_din       <= '0;
      r_wr_count  <= '0;
      r_wr_ready  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_cpu_n_clr <= 1'b0;
      r_run_en    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr <= wr_addr;
        r_din  <= wr_data;
      end
      r_wr_count  <= w_count_next;
      r_wr_ready  <= (w_state_next == S_PROG);
      r_ram_we    <= (w_state_next == S_WRITE);
      r_cpu_n_clr <= (w_state_next != S_CLEAR);
      r_run_en    <= (w_state_next == S_RUN);
      r_halted    <= (w_state_next == S_HALTED);
    end
  end

  // The controller owns the RAM address and output enable only while running;
  // otherwise the RAM output stays disabled.
  assign ram_addr  = (r_state == S_RUN) ? ctrl_addr : r_addr;
  assign ram_n_ce  = (r_state == S_RUN) ? ctrl_n_ce : 1'b1;
  assign ram_din   = r_din;
  assign ram_we    = r_ram_we;
  assign wr_ready  = r_wr_ready;
  assign cpu_n_clr = r_cpu_n_clr;
  assign run_en    = r_run_en;
  assign halted    = r_halted;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_ram_prog_sequencer.sv
// Bench for ram_prog_sequencer: directed vector table, hand-written corner
// sequences (counter saturation, asynchronous reset), then randomized traffic
// checked against a mode-level reference model.
module tb_ram_prog_sequencer;

  logic       clk;
  logic       n_clr;
  logic       prog_mode, start, wr_valid, hlt, ctrl_n_ce;
  logic [3:0] wr_addr, ctrl_addr;
  logic [7:0] wr_data;
  logic       wr_ready, ram_we, ram_n_ce, cpu_n_clr, run_en, halted;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [4:0] wr_count;

  typedef struct packed {
    logic       rdy;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic       nce;
    logic       nclr;
    logic       run;
    logic       hal;
    logic [4:0] cnt;
  } out_t;

  typedef struct {
    logic       pm, st, wv;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       hl;
    logic [3:0] ca;
    logic       cnce;
    out_t       exp;
  } vec_t;

  localparam out_t RST_OUT = '{rdy: 1'b0, we: 1'b0, addr: 4'h0, din: 8'h00, nce: 1'b1,
                               nclr: 1'b0, run: 1'b0, hal: 1'b0, cnt: 5'd0};

  // Reference-model modes
  localparam int MD_STOP = 0, MD_PROG = 1, MD_WRITE = 2, MD_CLEAR = 3, MD_RUN = 4, MD_HALT = 5;

  int         n_cmp = 0;
  int         n_err = 0;
  out_t       act;
  vec_t       vecs[20];
  int         m_mode;
  logic [3:0] m_addr;
  logic [7:0] m_din;
  int         m_cnt;

  ram_prog_sequencer dut (
    .clk(clk), .n_clr(n_clr), .prog_mode(prog_mode), .start(start),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .hlt(hlt), .ctrl_addr(ctrl_addr), .ctrl_n_ce(ctrl_n_ce), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_n_ce(ram_n_ce), .cpu_n_clr(cpu_n_clr),
    .run_en(run_en), .halted(halted), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = '{rdy: wr_ready, we: ram_we, addr: ram_addr, din: ram_din, nce: ram_n_ce,
                 nclr: cpu_n_clr, run: run_en, hal: halted, cnt: wr_count};

  function automatic out_t mko(input logic rdy, input logic we, input logic [3:0] a,
                               input logic [7:0] d, input logic nce, input logic nclr,
                               input logic run, input logic h, input logic [4:0] c);
    out_t o;
    o = '{rdy: rdy, we: we, addr: a, din: d, nce: nce, nclr: nclr, run: run, hal: h, cnt: c};
    return o;
  endfunction

  function automatic vec_t mkv(input logic pm, input logic st, input logic wv,
                               input logic [3:0] wa, input logic [7:0] wd, input logic hl,
                               input logic [3:0] ca, input logic cnce, input out_t e);
    vec_t v;
    v.pm = pm; v.st = st; v.wv = wv; v.wa = wa; v.wd = wd;
    v.hl = hl; v.ca = ca; v.cnce = cnce; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input out_t e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h din=%h nce=%b nclr=%b run=%b halted=%b cnt=%0d, required rdy=%b we=%b addr=%h din=%h nce=%b nclr=%b run=%b halted=%b cnt=%0d",
               name, act.rdy, act.we, act.addr, act.din, act.nce, act.nclr, act.run, act.hal, act.cnt,
               e.rdy, e.we, e.addr, e.din, e.nce, e.nclr, e.run, e.hal, e.cnt);
    end else begin
      $display("ok   %s: rdy=%b we=%b addr=%h din=%h nce=%b nclr=%b run=%b halted=%b cnt=%0d",
               name, act.rdy, act.we, act.addr, act.din, act.nce, act.nclr, act.run, act.hal, act.cnt);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic pm, input logic st, input logic wv, input logic [3:0] wa,
                      input logic [7:0] wd, input logic hl, input logic [3:0] ca,
                      input logic cnce);
    @(negedge clk);
    prog_mode = pm; start = st; wr_valid = wv; wr_addr = wa; wr_data = wd;
    hlt = hl; ctrl_addr = ca; ctrl_n_ce = cnce;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = MD_STOP; m_addr = 4'h0; m_din = 8'h00; m_cnt = 0;
  endtask

  // One rising edge of the reference model, using the currently driven inputs.
  task automatic model_step();
    case (m_mode)
      MD_STOP:  if (prog_mode) begin m_mode = MD_PROG; m_cnt = 0; end
                else if (start) m_mode = MD_CLEAR;
      MD_PROG:  if (wr_valid) begin
                  m_mode = MD_WRITE; m_addr = wr_addr; m_din = wr_data;
                  m_cnt = (m_cnt + 1 > 16) ? 16 : m_cnt + 1;
                end else if (!prog_mode) m_mode = MD_STOP;
      MD_WRITE: m_mode = prog_mode ? MD_PROG : MD_STOP;
      MD_CLEAR: m_mode = MD_RUN;
      MD_RUN:   if (prog_mode) m_mode = MD_STOP;
                else if (hlt) m_mode = MD_HALT;
      default:  if (prog_mode) begin m_mode = MD_PROG; m_cnt = 0; end
                else if (start) m_mode = MD_CLEAR;
    endcase
  endtask

  function automatic out_t model_out();
    out_t o;
    o.rdy  = (m_mode == MD_PROG);
    o.we   = (m_mode == MD_WRITE);
    o.addr = (m_mode == MD_RUN) ? ctrl_addr : m_addr;
    o.din  = m_din;
    o.nce  = (m_mode == MD_RUN) ? ctrl_n_ce : 1'b1;
    o.nclr = (m_mode != MD_CLEAR);
    o.run  = (m_mode == MD_RUN);
    o.hal  = (m_mode == MD_HALT);
    o.cnt  = 5'(m_cnt);
    return o;
  endfunction

  initial begin
    vecs[0]  = mkv(1,0,0,4'h0,8'h00,0,4'h0,1, mko(1,0,4'h0,8'h00,1,1,0,0,5'd0));
    vecs[1]  = mkv(1,0,1,4'h0,8'h1F,0,4'h0,1, mko(0,1,4'h0,8'h1F,1,1,0,0,5'd1));
    vecs[2]  = mkv(1,0,0,4'h0,8'h00,0,4'h0,1, mko(1,0,4'h0,8'h1F,1,1,0,0,5'd1));
    vecs[3]  = mkv(1,0,1,4'h1,8'h2E,0,4'h0,1, mko(0,1,4'h1,8'h2E,1,1,0,0,5'd2));
    vecs[4]  = mkv(1,0,0,4'h0,8'h00,0,4'h0,1, mko(1,0,4'h1,8'h2E,1,1,0,0,5'd2));
    vecs[5]  = mkv(1,0,1,4'h2,8'hE0,0,4'h0,1, mko(0,1,4'h2,8'hE0,1,1,0,0,5'd3));
    vecs[6]  = mkv(0,0,0,4'h0,8'h00,0,4'h0,1, mko(0,0,4'h2,8'hE0,1,1,0,0,5'd3));
    vecs[7]  = mkv(0,1,0,4'h0,8'h00,0,4'h0,1, mko(0,0,4'h2,8'hE0,1,0,0,0,5'd3));
    vecs[8]  = mkv(0,0,0,4'h0,8'h00,0,4'h5,0, mko(0,0,4'h5,8'hE0,0,1,1,0,5'd3));
    vecs[9]  = mkv(0,0,0,4'h0,8'h00,0,4'h5,1, mko(0,0,4'h5,8'hE0,1,1,1,0,5'd3));
    vecs[10] = mkv(0,0,1,4'h7,8'h55,0,4'h9,0, mko(0,0,4'h9,8'hE0,0,1,1,0,5'd3));
    vecs[11] = mkv(0,0,0,4'h0,8'h00,1,4'h3,0, mko(0,0,4'h2,8'hE0,1,1,0,1,5'd3));
    vecs[12] = mkv(0,1,0,4'h0,8'h00,0,4'h0,1, mko(0,0,4'h2,8'hE0,1,0,0,0,5'd3));
    vecs[13] = mkv(0,0,0,4'h0,8'h00,0,4'h4,0, mko(0,0,4'h4,8'hE0,0,1,1,0,5'd3));
    vecs[14] = mkv(1,1,0,4'h0,8'h00,0,4'h4,0, mko(0,0,4'h2,8'hE0,1,1,0,0,5'd3));
    vecs[15] = mkv(1,1,0,4'h0,8'h00,0,4'h0,1, mko(1,0,4'h2,8'hE0,1,1,0,0,5'd0));
    vecs[16] = mkv(1,0,1,4'hF,8'hA5,0,4'h0,1, mko(0,1,4'hF,8'hA5,1,1,0,0,5'd1));
    vecs[17] = mkv(0,0,0,4'h0,8'h00,0,4'h0,1, mko(0,0,4'hF,8'hA5,1,1,0,0,5'd1));
    vecs[18] = mkv(1,0,0,4'h0,8'h00,0,4'h0,1, mko(1,0,4'hF,8'hA5,1,1,0,0,5'd0));
    vecs[19] = mkv(0,0,0,4'h0,8'h00,0,4'h0,1, mko(0,0,4'hF,8'hA5,1,1,0,0,5'd0));

    // Reset state before any clock edge
    n_clr = 1'b0; prog_mode = 0; start = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    hlt = 0; ctrl_addr = 0; ctrl_n_ce = 1;
    #2;
    check("reset", RST_OUT);
    @(negedge clk);
    n_clr = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", mko(0,0,4'h0,8'h00,1,1,0,0,5'd0));

    // Directed table
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].pm, vecs[i].st, vecs[i].wv, vecs[i].wa, vecs[i].wd,
           vecs[i].hl, vecs[i].ca, vecs[i].cnce);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Seventeen writes: counter saturates at 16
    step(1,0,0,4'h0,8'h00,0,4'h0,1);
    check("sat_enter", mko(1,0,4'hF,8'hA5,1,1,0,0,5'd0));
    for (int i = 0; i < 17; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      logic [4:0] c;
      a = 4'(i);
      d = 8'(i * 3 + 1);
      c = (i + 1 > 16) ? 5'd16 : 5'(i + 1);
      step(1,0,1,a,d,0,4'h0,1);
      check($sformatf("sat_wr%0d", i), mko(0,1,a,d,1,1,0,0,c));
      step(1,0,0,4'h0,8'h00,0,4'h0,1);
      check($sformatf("sat_prog%0d", i), mko(1,0,a,d,1,1,0,0,c));
    end

    // Reset asserted mid-write drops ram_we without a clock edge
    step(1,0,1,4'h3,8'h77,0,4'h0,1);
    check("wr_before_rst", mko(0,1,4'h3,8'h77,1,1,0,0,5'd16));
    #2 n_clr = 1'b0;
    #1 check("rst_mid_write", RST_OUT);
    prog_mode = 0; wr_valid = 0;
    @(negedge clk);
    n_clr = 1'b1;
    @(posedge clk);
    #1 check("rst_wr_release", mko(0,0,4'h0,8'h00,1,1,0,0,5'd0));

    // Reset asserted mid-run
    step(0,1,0,4'h0,8'h00,0,4'h0,1);
    check("clr_before_rst", mko(0,0,4'h0,8'h00,1,0,0,0,5'd0));
    step(0,0,0,4'h0,8'h00,0,4'h5,0);
    check("run_before_rst", mko(0,0,4'h5,8'h00,0,1,1,0,5'd0));
    #2 n_clr = 1'b0;
    #1 check("rst_mid_run", RST_OUT);
    @(negedge clk);
    n_clr = 1'b1;
    @(posedge clk);
    #1 check("rst_run_release", mko(0,0,4'h0,8'h00,1,1,0,0,5'd0));

    // Randomized traffic against the reference model
    model_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        n_clr = 1'b0;
        #1 check($sformatf("rnd_rst%0d", i), RST_OUT);
        model_reset();
        @(negedge clk);
        n_clr = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) prog_mode = ~prog_mode;
      start     = ($urandom_range(0, 3) == 0);
      wr_valid  = ($urandom_range(0, 1) == 0);
      wr_addr   = 4'($urandom);
      wr_data   = 8'($urandom);
      hlt       = ($urandom_range(0, 5) == 0);
      ctrl_addr = 4'($urandom);
      ctrl_n_ce = 1'($urandom);
      @(posedge clk);
      #1;
      model_step();
      check($sformatf("rnd%0d", i), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_prog_sequencer.md
RAM_PROG_SEQUENCER -- requirements
Module: ram_prog_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16-word RAM).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_clr  input  1  asynchronous, active-low reset.
REQ-005 prog_mode  input  1  1 = program mode requested, 0 = run mode requested.
REQ-006 start  input  1  run-start request, level-sampled each cycle.
REQ-007 wr_valid  input  1  host byte-write request.
REQ-008 wr_addr  input  ADDR_W  host write address.
REQ-009 wr_data  input  DATA_W  host write data.
REQ-010 wr_ready  output  1  block accepts a host write this cycle.
REQ-011 hlt  input  1  halt decoded by the run-mode controller.
REQ-012 ctrl_addr  input  ADDR_W  MAR contents from datapath.
REQ-013 ctrl_n_ce  input  1  controller RAM output enable, active low.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_din  output  DATA_W  RAM write data.
REQ-016 ram_we  output  1  RAM write strobe, active high.
REQ-017 ram_n_ce  output  1  RAM bus output enable, active low.
REQ-018 cpu_n_clr  output  1  active-low clear to PC and controller.
REQ-019 run_en  output  1  controller clock enable.
REQ-020 halted  output  1  program halted.
REQ-021 wr_count  output  ADDR_W+1  bytes written since the last entry to PROG from STOP or HALTED.

Function
REQ-022 The FSM SHALL have six states: STOP, PROG, WRITE, CLEAR, RUN, HALTED; all outputs SHALL be registered except ram_addr and ram_n_ce in RUN.
REQ-023 STOP: prog_mode=1 -> PROG; else start=1 -> CLEAR; else stay; prog_mode wins when both are asserted.
REQ-024 PROG: wr_ready=1; wr_valid=1 -> capture wr_addr/wr_data and go to WRITE; else prog_mode=0 -> STOP; a same-cycle write wins over mode exit.
REQ-025 WRITE: wr_ready=0, ram_we=1 for exactly one cycle with the captured address/data, wr_count+1 saturating at 2^ADDR_W.
REQ-026 WRITE exit: prog_mode=1 -> PROG, else -> STOP; the write SHALL always complete.
REQ-027 Consecutive host writes SHALL sustain one write per two cycles; wr_valid outside PROG SHALL be ignored with no side effect.
REQ-028 CLEAR: cpu_n_clr=0 for exactly one cycle, run_en=0, halted=0, then RUN.
REQ-029 RUN: run_en=1, ram_addr=ctrl_addr, ram_n_ce=ctrl_n_ce combinationally, ram_we=0.
REQ-030 RUN exit: prog_mode=1 -> STOP (abort); else hlt=1 -> HALTED.
REQ-031 HALTED: run_en=0, halted=1; prog_mode=1 -> PROG; else start=1 -> CLEAR.
REQ-032 In all states other than RUN, ram_addr SHALL be the captured host address and ram_n_ce=1, so RAM never drives the bus outside RUN.
REQ-033 wr_count SHALL clear to 0 on every entry to PROG from STOP or HALTED, and hold otherwise.
REQ-034 ram_we and run_en SHALL never be 1 in the same cycle.

Reset
REQ-035 n_clr=0 SHALL immediately force STOP, wr_ready=0, ram_we=0, ram_addr=0, ram_din=0, ram_n_ce=1, cpu_n_clr=0, run_en=0, halted=0, wr_count=0.
REQ-036 cpu_n_clr SHALL return to 1 on the first rising edge after n_clr deasserts.
REQ-037 Reset asserted mid-WRITE SHALL drop ram_we asynchronously; the byte is not guaranteed written.

Verification
REQ-038 Program: reset, prog_mode=1, write 0x1F@0, 0x2E@1, 0xE0@2 back-to-back -> three single-cycle ram_we pulses two cycles apart with matching ram_addr/ram_din; wr_count=3.
REQ-039 Run: prog_mode=0, start=1 -> one-cycle cpu_n_clr=0, then run_en=1; ram_addr tracks ctrl_addr=5 and ram_n_ce tracks ctrl_n_ce in the same cycle.
REQ-040 Halt/rerun: hlt=1 in RUN -> next cycle run_en=0, halted=1; start=1 -> CLEAR then RUN, halted=0.
REQ-041 Priority: start=1 and prog_mode=1 together in STOP -> PROG entered, no cpu_n_clr pulse; prog_mode=1 in RUN -> STOP, run_en=0, ram_n_ce=1.
REQ-042 Boundaries: write 17 bytes -> wr_count saturates at 16; wr_valid pulsed in RUN -> no ram_we; prog_mode dropped while in WRITE -> write completes, then STOP.
REQ-043 Reset mid-operation: n_clr=0 during RUN -> all outputs take the REQ-035 values without waiting for a clock edge.
